program_loader: RTL and testbench



---
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader.sv | 182 ++++++++++++++++++
 tb/tb_program_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Instruction-field stream between a host and program_loader.
// Signals: in_valid/in_ready handshake plus the instruction fields
// (in_icode, in_ifun, in_rA, in_rB, in_rd, in_valC) and in_last,
// which marks the final instruction of a program.
// Modports: master drives the bundle, slave (the loader) drives in_ready.
interface program_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [2:0]  in_rA;
  logic [2:0]  in_rB;
  logic [2:0]  in_rd;
  logic [14:0] in_valC;
  logic        in_last;

  modport master (
    output in_valid, in_icode, in_ifun, in_rA, in_rB, in_rd, in_valC, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_rA, in_rB, in_rd, in_valC, in_last,
    output in_ready
  );
endinterface

// File: rtl/program_loader.sv
// Loads packed instruction words into processor RAM from address 0, then on
// start pulses cpu_reset for one cycle and holds working for run_len cycles
// (run_len == 0 runs until clear).
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   in_s                 instruction-field stream (slave side)
//   start, clear         single-cycle command pulses (clear wins)
//   run_len              run length in cycles, 0 = unbounded
//   addr, wr, wdata      RAM write port
//   working, cpu_reset   processor enable and reset
//   loaded, full, done   status flags
//   count                number of words loaded
module program_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  program_loader_if.slave     in_s,
  input  logic                start,
  input  logic                clear,
  input  logic [CNT_W-1:0]    run_len,
  output logic [ADDR_W-1:0]   addr,
  output logic                wr,
  output logic [31:0]         wdata,
  output logic                working,
  output logic                cpu_reset,
  output logic                loaded,
  output logic                full,
  output logic                done,
  output logic [ADDR_W:0]     count
);

  localparam int unsigned COUNT_W = ADDR_W + 1;
  localparam int unsigned WORD_W  = 32;
  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_PRST,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic                wr_q, wr_d;
  logic                working_q, working_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                loaded_q, loaded_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic                in_ready_q, in_ready_d;

  logic                hs_c;
  logic [WORD_W-1:0]   packed_c;

  assign hs_c     = in_s.in_valid & in_ready_q;
  assign packed_c = {in_s.in_icode, in_s.in_ifun, in_s.in_rA, in_s.in_rB,
                     in_s.in_rd, in_s.in_valC};

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    run_cnt_d   = run_cnt_q;
    wr_d        = 1'b0;
    working_d   = working_q;
    cpu_reset_d = 1'b0;
    loaded_d    = loaded_q;
    full_d      = full_q;
    done_d      = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (hs_c) begin
          wr_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = packed_c;
          count_d = count_q + COUNT_W'(1);
          if (in_s.in_last) begin
            state_d  = S_LOADED;
            loaded_d = 1'b1;
          end else if (count_q == LAST_IDX) begin
            state_d  = S_LOADED;
            loaded_d = 1'b1;
            full_d   = 1'b1;
          end
        end
      end
      S_LOADED, S_DONE: begin
        if (start) begin
          state_d     = S_PRST;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
        end
      end
      S_PRST: begin
        state_d   = S_RUN;
        run_cnt_d = run_len;
        working_d = 1'b1;
      end
      S_RUN: begin
        // A zero counter never reaches 1, so run_len == 0 runs until clear
        if (run_cnt_q == CNT_W'(1)) begin
          state_d   = S_DONE;
          working_d = 1'b0;
          done_d    = 1'b1;
        end else if (run_cnt_q != '0) begin
          run_cnt_d = run_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // clear overrides everything, including a same-cycle handshake or start
    if (clear) begin
      state_d     = S_IDLE;
      count_d     = '0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = 1'b0;
      working_d   = 1'b0;
      cpu_reset_d = 1'b0;
      loaded_d    = 1'b0;
      full_d      = 1'b0;
      done_d      = 1'b0;
    end

    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      run_cnt_q   <= '0;
      wr_q        <= 1'b0;
      working_q   <= 1'b0;
      cpu_reset_q <= 1'b0;
      loaded_q    <= 1'b0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      run_cnt_q   <= run_cnt_d;
      wr_q        <= wr_d;
      working_q   <= working_d;
      cpu_reset_q <= cpu_reset_d;
      loaded_q    <= loaded_d;
      full_q      <= full_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_s.in_ready = in_ready_q;
  assign addr          = addr_q;
  assign wr            = wr_q;
  assign wdata         = wdata_q;
  assign working       = working_q;
  assign cpu_reset     = cpu_reset_q;
  assign loaded        = loaded_q;
  assign full          = full_q;
  assign done          = done_q;
  assign count         = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, single and burst loads, runs,
// clear priority, overflow and asynchronous reset during a run.
module tb_program_loader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        clear;
  logic [15:0] run_len;
  logic [8:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        working;
  logic        cpu_reset;
  logic        loaded;
  logic        full;
  logic        done;
  logic [9:0]  count;

  int checks   = 0;
  int failures = 0;

  program_loader_if bus ();

  program_loader #(
    .ADDR_W (9),
    .DEPTH  (512),
    .CNT_W  (16)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_s      (bus.slave),
    .start     (start),
    .clear     (clear),
    .run_len   (run_len),
    .addr      (addr),
    .wr        (wr),
    .wdata     (wdata),
    .working   (working),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .full      (full),
    .done      (done),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; return at the following falling edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_bundle(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [2:0] ra, input logic [2:0] rb,
                            input logic [2:0] rd, input logic [14:0] vc,
                            input logic last);
    bus.in_icode = ic;
    bus.in_ifun  = fn;
    bus.in_rA    = ra;
    bus.in_rB    = rb;
    bus.in_rd    = rd;
    bus.in_valC  = vc;
    bus.in_last  = last;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench did not complete");
  end

  initial begin
    logic [31:0] burst_exp [4];
    int wcnt;
    int overlap;
    int errs;

    burst_exp[0] = 32'h2028_0100;
    burst_exp[1] = 32'h2128_8101;
    burst_exp[2] = 32'h2229_0102;
    burst_exp[3] = 32'h2329_8103;

    reset_n      = 1'b1;
    start        = 1'b0;
    clear        = 1'b0;
    run_len      = 16'd0;
    bus.in_valid = 1'b0;
    set_bundle(4'd0, 4'd0, 3'd0, 3'd0, 3'd0, 15'd0, 1'b0);

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wr",        64'(wr),        64'd0);
    chk("rst_working",   64'(working),   64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("rst_loaded",    64'(loaded),    64'd0);
    chk("rst_full",      64'(full),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_addr",      64'(addr),      64'd0);
    chk("rst_wdata",     64'(wdata),     64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("idle_ready", 64'(bus.in_ready), 64'd1);

    // start is ignored in IDLE
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_start_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("idle_start_ready",     64'(bus.in_ready), 64'd1);

    // Handshake together with clear is discarded
    set_bundle(4'd7, 4'd7, 3'd7, 3'd7, 3'd7, 15'h7fff, 1'b1);
    bus.in_valid = 1'b1;
    clear        = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    clear        = 1'b0;
    chk("hsclr_wr",    64'(wr),    64'd0);
    chk("hsclr_count", 64'(count), 64'd0);

    // Single word
    set_bundle(4'd1, 4'd0, 3'd0, 3'd0, 3'd3, 15'h1234, 1'b1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("single_wr",     64'(wr),    64'd1);
    chk("single_addr",   64'(addr),  64'd0);
    chk("single_wdata",  64'(wdata), 64'h1001_9234);
    tick();
    chk("single_wr_off",  64'(wr),           64'd0);
    chk("single_loaded",  64'(loaded),       64'd1);
    chk("single_count",   64'(count),        64'd1);
    chk("single_ready",   64'(bus.in_ready), 64'd0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_loaded", 64'(loaded),       64'd0);
    chk("clr_count",  64'(count),        64'd0);
    chk("clr_ready",  64'(bus.in_ready), 64'd1);

    // Back-to-back burst of four
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_bundle(4'd2, 4'(k), 3'd1, 3'd2, 3'(k), 15'(32'h100 + k), k == 3);
      tick();
      chk($sformatf("burst_wr%0d", k),    64'(wr),    64'd1);
      chk($sformatf("burst_addr%0d", k),  64'(addr),  64'(k));
      chk($sformatf("burst_wdata%0d", k), 64'(wdata), 64'(burst_exp[k]));
    end
    bus.in_valid = 1'b0;
    chk("burst_count",  64'(count),        64'd4);
    chk("burst_loaded", 64'(loaded),       64'd1);
    chk("burst_full",   64'(full),         64'd0);
    chk("burst_ready",  64'(bus.in_ready), 64'd0);
    tick();
    chk("burst_wr_off", 64'(wr), 64'd0);

    // Two runs of five cycles
    run_len = 16'd5;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("run%0d_cpu_reset", r), 64'(cpu_reset), 64'd1);
      chk($sformatf("run%0d_work_prst", r), 64'(working),   64'd0);
      chk($sformatf("run%0d_done_clr", r),  64'(done),      64'd0);
      wcnt    = 0;
      overlap = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (working) wcnt++;
        if (working && (cpu_reset || wr)) overlap++;
      end
      chk($sformatf("run%0d_work_cycles", r), 64'(wcnt),    64'd5);
      chk($sformatf("run%0d_overlap", r),     64'(overlap), 64'd0);
      chk($sformatf("run%0d_done", r),        64'(done),    64'd1);
      chk($sformatf("run%0d_work_end", r),    64'(working), 64'd0);
    end

    // clear beats start in DONE
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("prio_cpu_reset", 64'(cpu_reset),    64'd0);
    chk("prio_done",      64'(done),         64'd0);
    chk("prio_count",     64'(count),        64'd0);
    chk("prio_ready",     64'(bus.in_ready), 64'd1);
    chk("prio_loaded",    64'(loaded),       64'd0);
    tick();
    chk("prio_cpu_reset2", 64'(cpu_reset), 64'd0);

    // Overflow: 512 words with no in_last
    errs = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      set_bundle(4'd0, 4'd0, 3'd0, 3'd0, 3'd0, 15'(i), 1'b0);
      tick();
      if (!(wr === 1'b1 && addr === 9'(i))) errs++;
    end
    chk("ovf_seq_errs", 64'(errs),         64'd0);
    chk("ovf_last_addr", 64'(addr),        64'd511);
    chk("ovf_last_data", 64'(wdata),       64'h1ff);
    chk("ovf_full",     64'(full),         64'd1);
    chk("ovf_loaded",   64'(loaded),       64'd1);
    chk("ovf_count",    64'(count),        64'd512);
    chk("ovf_ready",    64'(bus.in_ready), 64'd0);
    tick();
    chk("ovf_no_wr",    64'(wr),    64'd0);
    chk("ovf_count2",   64'(count), 64'd512);
    bus.in_valid = 1'b0;

    // Asynchronous reset in the third RUN cycle of an unbounded run
    run_len = 16'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_working", 64'(working), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_working", 64'(working), 64'd0);
    chk("mid_rst_count",   64'(count),   64'd0);
    chk("mid_rst_loaded",  64'(loaded),  64'd0);
    chk("mid_rst_full",    64'(full),    64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready",   64'(bus.in_ready), 64'd1);
    chk("post_rst_count",   64'(count),        64'd0);
    chk("post_rst_working", 64'(working),      64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
